// File: rtl/input_port_ctrl.sv
// ---------------------------------------------------------------------------
// input_port_ctrl
//   Synchronizes, debounces and reports events on NUM_PINS asynchronous input
//   pins. The lowest-numbered pending pin is presented to a processor, which
//   acknowledges it with a one-cycle (or held) ack.
//
//   Optional feature macro: INPUT_PORT_EDGE_LATCH_EN
//     defined   : a pending bit per pin latches each 0->1 edge of the
//                 debounced level and is cleared by ack.
//     undefined : pending follows the debounced level and ack is ignored.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   pin_raw    in   [NUM_PINS] asynchronous external pins
//   ack        in   processor acknowledges the reported pin
//   signal     out  registered, some pin event is pending
//   pin_in     out  [SEL_W] registered, index of lowest pending pin
//   pin_level  out  [NUM_PINS] registered debounced pin levels
// ---------------------------------------------------------------------------

// Per-pin lane: 2-flop synchronizer followed by a debounce counter.
//   i_clk, i_rst : clock, synchronous reset
//   i_raw        : asynchronous pin
//   o_level      : registered debounced level
//   o_rise       : combinational, o_level goes 0->1 at the coming edge
module input_port_lane #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_sync1;
    logic       r_sync2;
    logic [7:0] r_cnt;
    logic       r_level;
    logic       w_flip;

    // The DEBOUNCE_CYCLES-th consecutive differing edge commits the new level.
    assign w_flip  = (r_sync2 != r_level) && (r_cnt == CNT_LAST);
    assign o_rise  = w_flip && r_sync2;
    assign o_level = r_level;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end
endmodule

module input_port_ctrl #(
    parameter int NUM_PINS        = 4,
    parameter int SEL_W           = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] pin_raw,
    input  logic                ack,
    output logic                signal,
    output logic [SEL_W-1:0]    pin_in,
    output logic [NUM_PINS-1:0] pin_level
);
    logic [NUM_PINS-1:0] w_rise;
    logic [NUM_PINS-1:0] w_pend;
    logic                w_any;
    logic [SEL_W-1:0]    w_sel;

    for (genvar g = 0; g < NUM_PINS; g++) begin : g_lane
        input_port_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .i_clk  (clk),
            .i_rst  (rst),
            .i_raw  (pin_raw[g]),
            .o_level(pin_level[g]),
            .o_rise (w_rise[g])
        );
    end

`ifdef INPUT_PORT_EDGE_LATCH_EN
    logic [NUM_PINS-1:0] r_pend;
    logic [NUM_PINS-1:0] w_clr;
    logic                r_acked;
    logic                w_ack_ok;

    // signal/pin_in lag the pending clear by one edge, so an ack is refused
    // on the edge right after an accepted one: a held ack then clears at most
    // one pin per reported pin_in value.
    assign w_ack_ok = ack && signal && !r_acked;

    always_comb begin
        w_clr = '0;
        if (w_ack_ok) w_clr[pin_in] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend  <= '0;
            r_acked <= 1'b0;
        end else begin
            // A new rise wins over a coincident clear of the same pin.
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            r_acked <= w_ack_ok;
        end
    end

    assign w_pend = r_pend;
`else
    logic w_unused;
    assign w_unused = ^{w_rise, ack};
    assign w_pend   = pin_level;
`endif

    // Fixed priority: lowest pending index wins.
    always_comb begin
        w_any = |w_pend;
        w_sel = '0;
        for (int i = NUM_PINS - 1; i >= 0; i--) begin
            if (w_pend[i]) w_sel = SEL_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            signal <= 1'b0;
            pin_in <= '0;
        end else begin
            signal <= w_any;
            pin_in <= w_sel;
        end
    end
endmodule

// File: tb/tb_input_port_ctrl.sv
module tb_input_port_ctrl;
    localparam int NP = 4;
    localparam int SW = 2;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] pin_raw = '0;
    logic          ack = 1'b0;
    logic          signal;
    logic [SW-1:0] pin_in;
    logic [NP-1:0] pin_level;

    int checks = 0;
    int errors = 0;

    input_port_ctrl #(.NUM_PINS(NP), .SEL_W(SW), .DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .pin_raw  (pin_raw),
        .ack      (ack),
        .signal   (signal),
        .pin_in   (pin_in),
        .pin_level(pin_level)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples per edge, debounced level by a window rule
    // (level flips once the last D synchronized samples all disagree with it
    // and no flip/reset happened inside that window), pending as a bit set.
    logic [NP-1:0] hist [0:8191];
    int            en = 0;
    int            last_flip [NP];
    logic [NP-1:0] m_level = '0;
    logic [NP-1:0] m_pend = '0;
    logic          m_sig = 1'b0;
    logic [SW-1:0] m_pin = '0;
    bit            m_acked = 1'b0;

    function automatic logic [SW-1:0] lowest(input logic [NP-1:0] p);
        logic [SW-1:0] r;
        r = '0;
        for (int i = NP - 1; i >= 0; i--) if (p[i]) r = SW'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [NP-1:0] raw, input logic a);
        logic [NP-1:0] nl;
        logic [NP-1:0] po;
        bit            all;
        pin_raw = raw;
        ack     = a;
        @(posedge clk);
        en++;
        hist[en] = raw;
        if (rst) begin
            hist[en]   = '0;
            hist[en-1] = '0;
            m_level = '0; m_pend = '0; m_sig = 1'b0; m_pin = '0; m_acked = 1'b0;
            for (int i = 0; i < NP; i++) last_flip[i] = en;
        end else begin
            nl = m_level;
            for (int i = 0; i < NP; i++) begin
                if (en - D >= last_flip[i]) begin
                    all = 1'b1;
                    for (int k = 0; k < D; k++)
                        if (hist[en-2-k][i] == m_level[i]) all = 1'b0;
                    if (all) begin
                        nl[i] = ~m_level[i];
                        last_flip[i] = en;
                    end
                end
            end
`ifdef INPUT_PORT_EDGE_LATCH_EN
            begin
                logic [NP-1:0] rise, clr;
                bit acc;
                po   = m_pend;
                rise = nl & ~m_level;
                acc  = a && m_sig && !m_acked;
                clr  = '0;
                if (acc) clr[m_pin] = 1'b1;
                m_pend  = (m_pend & ~clr) | rise;
                m_acked = acc;
            end
`else
            po = m_level;
`endif
            m_sig   = |po;
            m_pin   = lowest(po);
            m_level = nl;
        end
        #1;
        chk("cycle", 32'({pin_level, signal, pin_in}), 32'({m_level, m_sig, m_pin}));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step('0, 1'b0);
        step('0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [NP-1:0] base, gl;
        for (int i = 0; i < 8192; i++) hist[i] = '0;
        for (int i = 0; i < NP; i++) last_flip[i] = 0;

        // Reset state
        do_reset();
        chk("reset_outputs", 32'({pin_level, signal, pin_in}), 32'd0);

        // Single rise on pin 2: level after 6 edges, report after 7
        for (int e = 1; e <= 7; e++) begin
            step(4'b0100, 1'b0);
            if (e == 5) chk("lat_level_early", 32'(pin_level), 32'd0);
            if (e == 6) begin
                chk("lat_level", 32'(pin_level), 32'h4);
                chk("lat_sig_early", 32'(signal), 32'd0);
            end
            if (e == 7) chk("lat_report", 32'({signal, pin_in}), 32'({1'b1, 2'd2}));
        end

        // 3-cycle glitch on pin 1 never reaches any output
        do_reset();
        for (int e = 0; e < 15; e++) begin
            step((e < 3) ? 4'b0010 : 4'b0000, 1'b0);
            chk("glitch", 32'({pin_level, signal, pin_in}), 32'd0);
        end

`ifdef INPUT_PORT_EDGE_LATCH_EN
        // Pins 3 and 1 together: priority, then ack sequence
        do_reset();
        for (int e = 0; e < 7; e++) step(4'b1010, 1'b0);
        chk("prio_first", 32'({signal, pin_in}), 32'({1'b1, 2'd1}));
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b0);
        chk("prio_second", 32'({signal, pin_in}), 32'({1'b1, 2'd3}));
        step(4'b1010, 1'b1);
        step(4'b1010, 1'b0);
        chk("prio_empty", 32'(signal), 32'd0);

        // Ack of pin 0 coincides with a new rise of pin 0: set wins
        do_reset();
        for (int e = 0; e < 7; e++) step(4'b0001, 1'b0);
        for (int e = 0; e < 8; e++) step(4'b0000, 1'b0);
        chk("fall_keeps_pending", 32'({signal, pin_in}), 32'({1'b1, 2'd0}));
        for (int e = 0; e < 5; e++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        chk("set_wins_level", 32'(pin_level), 32'h1);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("set_wins_report", 32'({signal, pin_in}), 32'({1'b1, 2'd0}));
`else
        // Level mode: report follows the level, ack has no effect
        do_reset();
        for (int e = 0; e < 7; e++) step(4'b1000, 1'b0);
        chk("lvl_report", 32'({signal, pin_in}), 32'({1'b1, 2'd3}));
        for (int e = 0; e < 3; e++) step(4'b1000, 1'b1);
        chk("lvl_ack_ignored", 32'({signal, pin_in}), 32'({1'b1, 2'd3}));
        for (int e = 1; e <= 7; e++) begin
            step(4'b0000, 1'b0);
            if (e == 6) chk("lvl_fall_early", 32'(signal), 32'd1);
            if (e == 7) chk("lvl_fall", 32'(signal), 32'd0);
        end
`endif

        // Reset while pin 2 pending and held high
        do_reset();
        for (int e = 0; e < 7; e++) step(4'b0100, 1'b0);
        rst = 1'b1;
        step(4'b0100, 1'b0);
        rst = 1'b0;
        chk("rst_clears", 32'({pin_level, signal, pin_in}), 32'd0);
        for (int e = 1; e <= 7; e++) begin
            step(4'b0100, 1'b0);
            if (e == 6) chk("rst_rel_early", 32'(signal), 32'd0);
            if (e == 7) chk("rst_rel_report", 32'({signal, pin_in}), 32'({1'b1, 2'd2}));
        end

        // Random traffic against the model
        do_reset();
        base = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NP; i++) if ($urandom % 14 == 0) base[i] = ~base[i];
            gl = '0;
            for (int i = 0; i < NP; i++) if ($urandom % 10 == 0) gl[i] = 1'b1;
            rst = ($urandom % 400 == 0);
            step(base ^ gl, ($urandom % 3) == 0);
            rst = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_port_ctrl.md
INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_PINS, default 4, giving the number of input pins; legal range is 2..16.
REQ-002 The block SHALL have parameter SEL_W, default 2, giving the pin index width; it SHALL equal ceil(log2(NUM_PINS)).
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the debounce filter length; legal range is 1..255.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port pin_raw, input, NUM_PINS bits: asynchronous external pins; bit i is pin i.
REQ-007 The block SHALL have port ack, input, 1 bit: the processor acknowledges the currently reported pin.
REQ-008 The block SHALL have port signal, output, 1 bit, registered: at least one pin event is pending.
REQ-009 The block SHALL have port pin_in, output, SEL_W bits, registered: index of the reported pin.
REQ-010 The block SHALL have port pin_level, output, NUM_PINS bits, registered: debounced pin levels.

Function
REQ-011 Each pin SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each pin SHALL have a debounce counter that increments while the synchronized value differs from pin_level[i] and clears when they are equal.
REQ-013 pin_level[i] SHALL take the synchronized value, and the counter SHALL clear, on the DEBOUNCE_CYCLES-th consecutive edge of difference; shorter pulses SHALL never reach pin_level.
REQ-014 Latency from pin_raw change to pin_level SHALL be 2+DEBOUNCE_CYCLES edges, and to signal/pin_in one further edge.
REQ-015 A pending bit per pin SHALL set on a 0->1 transition of pin_level[i].
REQ-016 signal SHALL equal OR of pending bits; pin_in SHALL be the lowest pending index (fixed priority), or 0 when none is pending.
REQ-017 Handshake: ack sampled high while signal=1 SHALL clear pending[pin_in] at that edge; signal/pin_in SHALL update on the following edge.
REQ-018 ack while signal=0 SHALL be ignored; ack held high SHALL clear one pin per 2 edges (at most one clear per reported pin_in value).
REQ-019 When a new rising edge on pin k coincides with an ack of pin k, set SHALL win and pending[k] SHALL remain 1.
REQ-020 A second rising edge on an already-pending pin SHALL be merged (no count, no error).
REQ-021 A falling pin_level SHALL NOT clear its pending bit.

Reset
REQ-022 rst high at a clock edge SHALL clear synchronizers, counters, pin_level, pending, signal and pin_in to 0.
REQ-023 Reset mid-debounce or with events pending SHALL discard them; no event is reported for a pending bit cleared by reset.
REQ-024 A pin held high through reset release SHALL be reported as a new rising edge after 2+DEBOUNCE_CYCLES+1 edges.

Configuration
REQ-025 Macro INPUT_PORT_EDGE_LATCH_EN defined SHALL select the edge-latched pending/ack behaviour of REQ-015..REQ-021.
REQ-026 Without INPUT_PORT_EDGE_LATCH_EN, pending SHALL equal pin_level (level mode), ack SHALL be ignored, and signal/pin_in SHALL follow REQ-016 on the levels.

Verification (NUM_PINS=4, DEBOUNCE_CYCLES=4, macro defined unless stated)
REQ-027 pin_raw=4'b0100 from reset-idle -> pin_level[2]=1 after 6 edges; signal=1, pin_in=2 after 7 edges.
REQ-028 3-cycle pulse on pin_raw[1] -> pin_level, signal and pin_in remain 0 throughout.
REQ-029 Pins 3 and 1 rise on the same edge -> pin_in=1; after ack, pin_in=3; after second ack, signal=0.
REQ-030 ack of pin 0 on the same edge as a new pin 0 rising edge -> signal stays 1 and pin_in stays 0.
REQ-031 rst pulsed while pin 2 pending and pin_raw[2] held high -> all outputs 0 after reset; signal=1, pin_in=2 exactly 7 edges after release.
REQ-032 Macro undefined, pin_raw=4'b1000 then 4'b0000 -> signal=1, pin_in=3 while high, regardless of ack; signal=0 seven edges after the fall.
